shift_seq_ctrl: RTL
===================

Name: shift_seq_ctrl

Overview:
- Frame controller that sequences a left-shift serial datapath.
- Accepts a parallel word and a bit count through a valid/ready handshake, then shifts the word out MSB-first while shifting serial_in into the LSB of a capture register (full duplex).
- Holds each bit for DIV clock cycles and presents the captured word on a valid/ready output.
- Sits between a parallel requester (CPU/FSM) and a bit-serial link or peripheral.

Parameters:
- WIDTH, 8: maximum frame length in bits; width of in_data and out_data (>=2).
- DIV, 2: clock cycles per bit period (>=1).

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  requester has a frame to send.
- in_ready  output  1  controller can accept a frame.
- in_data  input  WIDTH  parallel word to transmit; bit WIDTH-1 is sent first.
- in_len  input  $clog2(WIDTH+1)  number of bits to shift; 0 or >WIDTH means WIDTH.
- abort  input  1  synchronous frame cancel.
- serial_in  input  1  serial receive bit.
- serial_out  output  1  serial transmit bit.
- shift_active  output  1  high while a frame is on the wire (frame enable/select).
- out_valid  output  1  captured word available.
- out_ready  input  1  consumer accepts the captured word.
- out_data  output  WIDTH  captured word, right-aligned; unused upper bits are 0.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, high) forces the following, regardless of state, including mid-frame:
  - state=IDLE; tx_reg, rx_reg, bit_cnt and div_cnt are all 0.
  - Outputs: in_ready=1, serial_out=0, shift_active=0, out_valid=0, out_data=0, busy=0.
- States are IDLE, SHIFT and DONE. in_ready=1 only in IDLE. out_valid=1 only in DONE. shift_active=1 only in SHIFT.
- IDLE:
  - On in_valid&&in_ready at edge E, latch tx_reg=in_data, rx_reg=0, len=effective in_len, bit_cnt=0 and div_cnt=0, then go to SHIFT.
  - in_data and in_len are sampled only at E.
- SHIFT:
  - serial_out=tx_reg[WIDTH-1]. Bit k is driven for cycles E+1+k*DIV through E+(k+1)*DIV.
  - div_cnt increments every cycle. At a period end (div_cnt==DIV-1):
    - rx_reg <= {rx_reg[WIDTH-2:0], serial_in}, so serial_in is sampled on the last cycle of each bit period.
    - tx_reg <= tx_reg<<1, div_cnt <= 0, bit_cnt <= bit_cnt+1.
  - At the period end where bit_cnt==len-1, the shift is performed and the FSM goes to DONE.
  - out_valid rises exactly len*DIV cycles after E.
- DONE:
  - out_data=rx_reg, holding the last len received bits, right-aligned, first-received bit at position len-1.
  - out_valid and out_data stay stable until out_ready. On out_valid&&out_ready, go to IDLE; in_ready=1 the next cycle.
  - A new frame cannot be accepted in the same cycle the output is consumed (minimum one IDLE cycle between frames).
- abort:
  - In SHIFT: go to IDLE at the next edge. shift_active=0 and serial_out=0 from the next cycle. No out_valid. rx_reg is discarded.
  - Ignored in IDLE and in DONE.
  - abort asserted in the same cycle as a period end that would finish the frame takes priority: no DONE.
- serial_out is 0 outside SHIFT.
- Counter widths: bit_cnt is $clog2(WIDTH+1) bits and div_cnt is max($clog2(DIV),1) bits; neither wraps within a legal frame.
- DIV=1: one bit per cycle, and serial_in is sampled every cycle in SHIFT.

Test Plan:
1. WIDTH=8, DIV=2, serial_out looped to serial_in; send in_data=8'hA5, in_len=8.
   - serial_out is 1,0,1,0,0,1,0,1, each bit held 2 cycles.
   - out_valid rises 16 cycles after accept; out_data=8'hA5.
2. in_data=8'hC0, in_len=4, loopback.
   - Wire carries 1,1,0,0; shift_active is high 8 cycles.
   - out_data=8'h0C.
3. serial_in tied 1, in_len=0.
   - Treated as 8 bits; out_data=8'hFF after 16 cycles.
   - in_len=9 behaves identically.
4. out_ready held low 5 cycles after out_valid.
   - out_valid stays 1, out_data stable, in_ready=0.
   - in_ready=1 one cycle after the out_ready handshake.
5. abort pulsed during bit 3 of an 8-bit frame.
   - shift_active and serial_out go to 0 next cycle; out_valid never asserts; in_ready=1.
   - The following frame 8'h3C completes correctly.
6. reset asserted asynchronously mid-SHIFT, between clock edges.
   - All outputs immediately take reset values.
   - After release, a frame 8'h81 (DIV=1, loopback) returns 8'h81 in 8 cycles.

Source files
------------

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: full-duplex MSB-first shift frame controller with valid/ready on both sides
module shift_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int DIV   = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  input  logic [$clog2(WIDTH+1)-1:0] in_len,
  input  logic                       abort,
  input  logic                       serial_in,
  output logic                       serial_out,
  output logic                       shift_active,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       busy
);
  localparam int LW = $clog2(WIDTH + 1);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] tx_q, tx_d, rx_q, rx_d;
  logic [LW-1:0] len_q, len_d, bit_q, bit_d, eff_len;
  logic [DW-1:0] div_q, div_d;
  logic period_end;
  assign eff_len    = (in_len == '0 || in_len > LW'(WIDTH)) ? LW'(WIDTH) : in_len;
  assign period_end = div_q == DW'(DIV - 1);
  assign in_ready     = state_q == IDLE;
  assign shift_active = state_q == SHIFT;
  assign out_valid    = state_q == DONE;
  assign busy         = state_q != IDLE;
  assign serial_out   = shift_active & tx_q[WIDTH-1];
  assign out_data     = out_valid ? rx_q : '0;
  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      tx_q    <= '0;
      rx_q    <= '0;
      len_q   <= '0;
      bit_q   <= '0;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      len_q   <= len_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
    end
  end
  // next state: accept, shift one bit per DIV cycles, abort wins over frame completion
  always_comb begin
    state_d = state_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    len_d   = len_q;
    bit_d   = bit_q;
    div_d   = div_q;
    case (state_q)
      IDLE: if (in_valid) begin
        tx_d    = in_data;
        rx_d    = '0;
        len_d   = eff_len;
        bit_d   = '0;
        div_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: if (abort) begin
        tx_d    = '0;
        rx_d    = '0;
        bit_d   = '0;
        div_d   = '0;
        state_d = IDLE;
      end else if (period_end) begin
        rx_d    = {rx_q[WIDTH-2:0], serial_in};
        tx_d    = tx_q << 1;
        div_d   = '0;
        bit_d   = bit_q + LW'(1);
        state_d = (bit_q == len_q - LW'(1)) ? DONE : SHIFT;
      end else begin
        div_d = div_q + DW'(1);
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
endmodule
